// File: rtl/seg_display_scan.sv
// Multiplexed 7-segment driver: signed value and string note, decimal conversion by repeated subtraction.
// Define SEG_DISPLAY_SCAN_BLANK_ZEROS_EN to blank leading zeros of the magnitude field.
module seg_display_scan #(
  parameter int NUM_DIGITS     = 8,
  parameter int MAG_DIGITS     = 3,
  parameter int VALUE_W        = 10,
  parameter int REFRESH_CYCLES = 2001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [VALUE_W-1:0] value,
  input  logic [2:0]                note,
  output logic                      done,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [7:0]                seg
);
  // state  | meaning
  // IDLE   | waiting for a value/note transfer
  // SIGN   | take magnitude and sign, range check
  // DIGIT  | one subtract-or-store step per cycle
  // COMMIT | copy shadow fields to the display registers
  typedef enum logic [1:0] {IDLE, SIGN, DIGIT, COMMIT} state_t;

  localparam int PW     = VALUE_W + 1;
  localparam int SCAN_W = $clog2(REFRESH_CYCLES);
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  // Powers that do not fit saturate to all ones, which no magnitude can reach.
  function automatic logic [PW-1:0] pow10_sat(input int k);
    longint p;
    p = 64'sd1;
    for (int i = 0; i < 8; i++)
      if (i < k) p = p * 64'sd10;
    if (p >= (longint'(1) << PW)) return '1;
    return p[PW-1:0];
  endfunction

  function automatic logic [7:0] dig_code(input logic [3:0] d);
    case (d)
      4'd0:    dig_code = 8'h03;
      4'd1:    dig_code = 8'h9F;
      4'd2:    dig_code = 8'h25;
      4'd3:    dig_code = 8'h0D;
      4'd4:    dig_code = 8'h99;
      4'd5:    dig_code = 8'h49;
      4'd6:    dig_code = 8'h41;
      4'd7:    dig_code = 8'h1F;
      4'd8:    dig_code = 8'h01;
      4'd9:    dig_code = 8'h09;
      default: dig_code = 8'hFF;
    endcase
  endfunction

  localparam logic [PW-1:0] POW [8] = '{pow10_sat(0), pow10_sat(1), pow10_sat(2), pow10_sat(3),
                                        pow10_sat(4), pow10_sat(5), pow10_sat(6), pow10_sat(7)};
  localparam logic [PW-1:0] LIMIT = pow10_sat(MAG_DIGITS);

  state_t               state_q, state_d;
  logic [VALUE_W-1:0]   val_q, val_d;
  logic [2:0]           note_q, note_d;
  logic [VALUE_W-1:0]   mag_q, mag_d;
  logic [2:0]           k_q, k_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           sign_q, sign_d;
  logic [7:0]           dig_q [MAG_DIGITS];
  logic [7:0]           dig_d [MAG_DIGITS];
  logic [7:0]           disp_q [NUM_DIGITS];
  logic [7:0]           disp_new [NUM_DIGITS];
  logic [SCAN_W-1:0]    scan_q;
  logic [IDX_W-1:0]     idx_q;
  logic [NUM_DIGITS-1:0] an_q, an_sel;
  logic [7:0]           seg_q, seg_sel;
  logic [VALUE_W-1:0]   mag_abs;
  logic [PW-1:0]        pow_k;
`ifdef SEG_DISPLAY_SCAN_BLANK_ZEROS_EN
  logic                 lead_zero;
`endif

  // Unsigned negate keeps -2^(VALUE_W-1) as 2^(VALUE_W-1).
  assign mag_abs  = val_q[VALUE_W-1] ? (-val_q) : val_q;
  assign pow_k    = POW[k_q];
  assign in_ready = (state_q == IDLE);
  assign done     = (state_q == COMMIT);
  assign an       = an_q;
  assign seg      = seg_q;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    note_d  = note_q;
    mag_d   = mag_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    dig_d   = dig_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          val_d   = value;
          note_d  = note;
          state_d = SIGN;
        end
      end
      SIGN: begin
        mag_d  = mag_abs;
        sign_d = val_q[VALUE_W-1] ? 8'hFD : 8'hFF;
        if ({1'b0, mag_abs} >= LIMIT) begin
          for (int i = 0; i < MAG_DIGITS; i++) dig_d[i] = 8'hFD;
          state_d = COMMIT;
        end else begin
          k_d     = 3'(MAG_DIGITS - 1);
          cnt_d   = 4'd0;
          state_d = DIGIT;
        end
      end
      DIGIT: begin
        if ({1'b0, mag_q} >= pow_k) begin
          mag_d = mag_q - pow_k[VALUE_W-1:0];
          cnt_d = cnt_q + 4'd1;
        end else begin
          for (int i = 0; i < MAG_DIGITS; i++)
            if (k_q == 3'(i)) dig_d[i] = dig_code(cnt_q);
          cnt_d = 4'd0;
          if (k_q == 3'd0) state_d = COMMIT;
          else             k_d = k_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int p = 0; p < NUM_DIGITS; p++) disp_new[p] = 8'hFF;
`ifdef SEG_DISPLAY_SCAN_BLANK_ZEROS_EN
    lead_zero = 1'b1;
`endif
    disp_new[0] = sign_q;
    for (int i = MAG_DIGITS - 1; i >= 0; i--) begin
      disp_new[MAG_DIGITS - i] = dig_q[i];
`ifdef SEG_DISPLAY_SCAN_BLANK_ZEROS_EN
      if (lead_zero && i != 0 && dig_q[i] == 8'h03) disp_new[MAG_DIGITS - i] = 8'hFF;
      else lead_zero = 1'b0;
`endif
    end
    case (note_q)
      3'd0, 3'd5: disp_new[NUM_DIGITS-1] = 8'h61;
      3'd1:       disp_new[NUM_DIGITS-1] = 8'h11;
      3'd2:       disp_new[NUM_DIGITS-1] = 8'h85;
      3'd3: begin
        disp_new[NUM_DIGITS-3] = 8'h49;
        disp_new[NUM_DIGITS-2] = 8'h03;
        disp_new[NUM_DIGITS-1] = 8'hE3;
      end
      3'd4:       disp_new[NUM_DIGITS-1] = 8'hC1;
      default:    disp_new[NUM_DIGITS-1] = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= '0;
      note_q  <= 3'd7;
      mag_q   <= '0;
      k_q     <= 3'd0;
      cnt_q   <= 4'd0;
      sign_q  <= 8'hFF;
      for (int i = 0; i < MAG_DIGITS; i++) dig_q[i] <= 8'hFF;
      for (int p = 0; p < NUM_DIGITS; p++) disp_q[p] <= 8'hFF;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      note_q  <= note_d;
      mag_q   <= mag_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      dig_q   <= dig_d;
      if (state_q == COMMIT) disp_q <= disp_new;
    end
  end

  // Position 0 (sign) drives the leftmost anode.
  always_comb begin
    seg_sel = 8'hFF;
    an_sel  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        seg_sel                 = disp_q[i];
        an_sel[NUM_DIGITS-1-i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= 8'hFF;
    end else begin
      if (scan_q == SCAN_W'(REFRESH_CYCLES - 1)) begin
        scan_q <= '0;
        idx_q  <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        scan_q <= scan_q + SCAN_W'(1);
      end
      an_q  <= an_sel;
      seg_q <= seg_sel;
    end
  end

endmodule
